// File: rtl/peripheral_msi_arbiter_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
`timescale 1ns/1ps
package peripheral_msi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Modular add for master indices: a + b wrapped into 0..n-1 (a, b < n).
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) begin
      s = s - n;
    end else begin
      s = s;
    end
    return s;
  endfunction

endpackage

// File: rtl/peripheral_msi_rr_select.sv
// Combinational round-robin picker: first request at or after ptr, wrapping upward.
`timescale 1ns/1ps
module peripheral_msi_rr_select
  import peripheral_msi_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index,
  output logic          valid
);

  // Scan from the pointer; the first hit suppresses every later candidate.
  always_comb begin
    logic [PW-1:0] pos_s;
    logic          hit_s;
    grant = '0;
    index = '0;
    valid = 1'b0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s        = PW'(wrap_add(int'(ptr), k, N));
      hit_s        = !valid && req[pos_s];
      grant[pos_s] = grant[pos_s] | hit_s;
      index        = hit_s ? pos_s : index;
      valid        = valid | hit_s;
    end
  end

endmodule

// File: rtl/peripheral_msi_arbiter_wb.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port,
// grant held for a whole CYC, optional watchdog forces ERR on stalled accesses.
`timescale 1ns/1ps
module peripheral_msi_arbiter_wb
  import peripheral_msi_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int PW     = $clog2(NUM_MASTERS);
  localparam int SW     = DW / 8;
  localparam int WW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;
  localparam bit WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e             state_r, state_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_s;
  logic [PW-1:0]          gidx_r, gidx_s;
  logic [PW-1:0]          ptr_r, ptr_s;
  logic [WW-1:0]          wdog_r, wdog_s;
  logic [NUM_MASTERS-1:0] sel_grant_s;
  logic [PW-1:0]          sel_idx_s;
  logic                   sel_valid_s;
  logic [PW-1:0]          next_ptr_s;
  logic                   gcyc_s, gstb_s, term_s, in_grant_s, in_abort_s;

  peripheral_msi_rr_select #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) u_rr_select (
    .req   (wbm_cyc_i),
    .ptr   (ptr_r),
    .grant (sel_grant_s),
    .index (sel_idx_s),
    .valid (sel_valid_s)
  );

  assign in_grant_s = (state_r == GRANT);
  assign in_abort_s = (state_r == ABORT);
  assign gcyc_s     = |(wbm_cyc_i & grant_r);
  assign gstb_s     = |(wbm_stb_i & grant_r);
  assign term_s     = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign next_ptr_s = PW'(wrap_add(int'(gidx_r), 1, NUM_MASTERS));

  // During ABORT the slave is idled while the master is told ERR.
  assign wbs_cyc_o = in_grant_s & gcyc_s;
  assign wbs_stb_o = wbs_cyc_o & gstb_s;
  assign wbm_ack_o = grant_r & {NUM_MASTERS{wbs_cyc_o & wbs_ack_i}};
  assign wbm_err_o = grant_r & {NUM_MASTERS{(wbs_cyc_o & wbs_err_i) | in_abort_s}};
  assign wbm_rty_o = grant_r & {NUM_MASTERS{wbs_cyc_o & wbs_rty_i}};
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign grant_o   = grant_r;
  assign timeout_o = in_abort_s;

  // One-hot AND-OR mux of the granted master's request fields onto the slave.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = 3'b000;
    wbs_bte_o = 2'b00;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      wbs_adr_o = wbs_adr_o | ({AW{grant_r[i]}} & wbm_adr_i[i*AW +: AW]);
      wbs_dat_o = wbs_dat_o | ({DW{grant_r[i]}} & wbm_dat_i[i*DW +: DW]);
      wbs_sel_o = wbs_sel_o | ({SW{grant_r[i]}} & wbm_sel_i[i*SW +: SW]);
      wbs_we_o  = wbs_we_o  | (grant_r[i] & wbm_we_i[i]);
      wbs_cti_o = wbs_cti_o | ({3{grant_r[i]}} & wbm_cti_i[i*3 +: 3]);
      wbs_bte_o = wbs_bte_o | ({2{grant_r[i]}} & wbm_bte_i[i*2 +: 2]);
    end
  end

  // Arbitration FSM and watchdog next-state logic.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    gidx_s  = gidx_r;
    ptr_s   = ptr_r;
    wdog_s  = '0;
    case (state_r)
      IDLE: begin
        if (sel_valid_s) begin
          state_s = GRANT;
          grant_s = sel_grant_s;
          gidx_s  = sel_idx_s;
        end else begin
          grant_s = '0;
        end
      end
      GRANT: begin
        if (!gcyc_s) begin
          state_s = IDLE;
          grant_s = '0;
          ptr_s   = next_ptr_s;
        end else if (WD_EN && wbs_stb_o && !term_s) begin
          // A termination on the expiry cycle takes the other branch, so it wins.
          if (wdog_r == WD_LAST) begin
            state_s = ABORT;
          end else begin
            wdog_s = wdog_r + WW'(1);
          end
        end else begin
          wdog_s = '0;
        end
      end
      ABORT: begin
        if (gcyc_s) begin
          state_s = GRANT;
        end else begin
          state_s = IDLE;
          grant_s = '0;
          ptr_s   = next_ptr_s;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      ptr_r   <= '0;
      wdog_r  <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      gidx_r  <= gidx_s;
      ptr_r   <= ptr_s;
      wdog_r  <= wdog_s;
    end
  end

endmodule

// File: tb/tb_peripheral_msi_arbiter_wb.sv
// Directed bench for peripheral_msi_arbiter_wb with a small memory slave model.
`timescale 1ns/1ps
module tb_peripheral_msi_arbiter_wb;
  import peripheral_msi_arbiter_pkg::*;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*4-1:0]   m_sel;
  logic [NM-1:0]     m_we, m_cyc, m_stb;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [NM*DW-1:0]  wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [NM-1:0]     grant_o;
  logic              timeout_o;

  logic              s_ack = 1'b0;
  logic              s_rty = 1'b0;
  logic [31:0]       s_dat = 32'h0;
  int                s_cnt = 0;
  int                s_delay;
  logic              s_use_rty;
  logic [31:0]       mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  peripheral_msi_arbiter_wb #(
    .NUM_MASTERS    (NM),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_adr_i (m_adr),
    .wbm_dat_i (m_dat),
    .wbm_sel_i (m_sel),
    .wbm_we_i  (m_we),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_cti_i (m_cti),
    .wbm_bte_i (m_bte),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_cti_o (wbs_cti_o),
    .wbs_bte_o (wbs_bte_o),
    .wbs_dat_i (s_dat),
    .wbs_ack_i (s_ack),
    .wbs_err_i (1'b0),
    .wbs_rty_i (s_rty),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  // Slave: terminates s_delay cycles after STB is first seen (0 = never responds).
  always @(posedge clk) begin
    if (wbs_cyc_o && wbs_stb_o && !s_ack && !s_rty) begin
      if (s_delay != 0 && s_cnt == s_delay - 1) begin
        s_cnt <= 0;
        if (s_use_rty) begin
          s_rty <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          s_dat <= mem[wbs_adr_o[9:2]];
          if (wbs_we_o) mem[wbs_adr_o[9:2]] <= wbs_dat_o;
        end
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      s_ack <= 1'b0;
      s_rty <= 1'b0;
      s_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [2:0] cti);
    m_adr[m*AW +: AW] = adr;
    m_dat[m*DW +: DW] = dat;
    m_sel[m*4 +: 4]   = 4'hF;
    m_cti[m*3 +: 3]   = cti;
    m_bte[m*2 +: 2]   = 2'b00;
    m_we[m]           = we;
    m_cyc[m]          = 1'b1;
    m_stb[m]          = 1'b1;
  endtask

  task automatic drop(input int m);
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  task automatic wait_term(input int m, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wbm_ack_o[m] || wbm_err_o[m] || wbm_rty_o[m]) && (n < limit));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int e;
    logic [3:0] oh;
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
    m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
    s_delay = 2;
    s_use_rty = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 128'(grant_o), 128'h0);
    chk("rst_cyc_stb", 128'({wbs_cyc_o, wbs_stb_o}), 128'h0);
    chk("rst_term", 128'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 128'h0);
    chk("rst_timeout", 128'(timeout_o), 128'h0);
    rst = 1'b0;

    // Single master write then readback.
    set_req(0, 1'b1, 32'h100, 32'hDEADBEEF, CTI_CLASSIC);
    @(negedge clk);
    chk("t1_grant", 128'(grant_o), 128'h1);
    chk("t1_cyc", 128'({wbs_cyc_o, wbs_stb_o}), 128'h3);
    chk("t1_adr", 128'(wbs_adr_o), 128'h100);
    chk("t1_wdat", 128'(wbs_dat_o), 128'hDEADBEEF);
    chk("t1_ctl", 128'({wbs_we_o, wbs_sel_o, wbs_cti_o, wbs_bte_o}), 128'({1'b1, 4'hF, 3'b000, 2'b00}));
    wait_term(0, 20, n);
    chk("t1_latency", 128'(n), 128'd2);
    chk("t1_ack", 128'(wbm_ack_o), 128'h1);
    drop(0);
    @(negedge clk);
    chk("t1_idle", 128'(grant_o), 128'h0);
    set_req(0, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    wait_term(0, 20, n);
    chk("t1_rd_ack", 128'(wbm_ack_o), 128'h1);
    chk("t1_rd_dat", wbm_dat_o, {4{32'hDEADBEEF}});
    drop(0);

    // Fairness: all four request, re-requesting after each access.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_grant", 128'(grant_o), 128'h0);
    rst = 1'b0;
    for (int m = 0; m < NM; m++) set_req(m, 1'b1, 32'h200 + 32'(4 * m), 32'(m), CTI_CLASSIC);
    for (int k = 0; k < 5; k++) begin
      e  = k % 4;
      oh = 4'b0001 << e;
      @(negedge clk);
      chk("fair_grant", 128'(grant_o), 128'(oh));
      wait_term(e, 20, n);
      chk("fair_ack", 128'(wbm_ack_o), 128'(oh));
      drop(e);
      @(negedge clk);
      chk("fair_dead", 128'({grant_o, wbs_cyc_o}), 128'h0);
      if (k < 4) set_req(e, 1'b1, 32'h200 + 32'(4 * e), 32'(e), CTI_CLASSIC);
      else begin
        m_cyc = '0;
        m_stb = '0;
      end
    end

    // Burst hold: master 1 8-beat INC burst while master 2 waits.
    @(negedge clk);
    set_req(2, 1'b0, 32'h300, 32'h0, CTI_CLASSIC);
    set_req(1, 1'b1, 32'h400, 32'hB0, CTI_INC);
    @(negedge clk);
    chk("burst_grant0", 128'(grant_o), 128'h2);
    for (int b = 0; b < 8; b++) begin
      wait_term(1, 20, n);
      chk("burst_grant", 128'(grant_o), 128'h2);
      chk("burst_ack", 128'(wbm_ack_o), 128'h2);
      if (b == 7) chk("burst_eob", 128'(wbs_cti_o), 128'(CTI_EOB));
      if (b < 6) set_req(1, 1'b1, 32'h400 + 32'(4 * (b + 1)), 32'hB0 + 32'(b + 1), CTI_INC);
      else if (b == 6) set_req(1, 1'b1, 32'h41C, 32'hB7, CTI_EOB);
      else drop(1);
    end
    @(negedge clk);
    chk("burst_dead", 128'(grant_o), 128'h0);
    @(negedge clk);
    chk("burst_next", 128'(grant_o), 128'h4);
    wait_term(2, 20, n);
    chk("m2_ack", 128'(wbm_ack_o), 128'h4);
    drop(2);

    // Watchdog expiry with a slave that never answers.
    @(negedge clk);
    s_delay = 0;
    set_req(3, 1'b1, 32'h500, 32'h55, CTI_CLASSIC);
    wait_term(3, 40, n);
    chk("to_latency", 128'(n), 128'd17);
    chk("to_err", 128'(wbm_err_o), 128'h8);
    chk("to_ack_rty", 128'({wbm_ack_o, wbm_rty_o}), 128'h0);
    chk("to_pulse", 128'(timeout_o), 128'h1);
    chk("to_cyc", 128'({wbs_cyc_o, wbs_stb_o}), 128'h0);
    @(negedge clk);
    chk("to_regrant", 128'({timeout_o, wbs_cyc_o, wbm_err_o}), 128'({1'b0, 1'b1, 4'b0000}));
    drop(3);
    @(negedge clk);
    chk("to_idle", 128'(grant_o), 128'h0);

    // ACK on the very cycle the watchdog would expire.
    s_delay = 15;
    set_req(0, 1'b1, 32'h600, 32'h12345678, CTI_CLASSIC);
    wait_term(0, 40, n);
    chk("ae_latency", 128'(n), 128'd16);
    chk("ae_ack", 128'(wbm_ack_o), 128'h1);
    chk("ae_no_err", 128'({wbm_err_o, timeout_o}), 128'h0);
    drop(0);
    @(negedge clk);
    chk("ae_after", 128'({timeout_o, wbm_err_o, grant_o}), 128'h0);

    // RTY routed to the granted master only.
    s_delay = 1;
    s_use_rty = 1'b1;
    set_req(1, 1'b0, 32'h700, 32'h0, CTI_CLASSIC);
    wait_term(1, 20, n);
    chk("rty_route", 128'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 128'h2);
    drop(1);
    @(negedge clk);
    s_use_rty = 1'b0;

    // Reset in the middle of a master 3 burst.
    set_req(3, 1'b1, 32'h800, 32'hC0, CTI_INC);
    for (int b = 0; b < 3; b++) begin
      wait_term(3, 20, n);
      chk("rb_ack", 128'(wbm_ack_o), 128'h8);
      set_req(3, 1'b1, 32'h800 + 32'(4 * (b + 1)), 32'hC0 + 32'(b + 1), CTI_INC);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rb_cyc", 128'({wbs_cyc_o, wbs_stb_o}), 128'h0);
    chk("rb_grant", 128'(grant_o), 128'h0);
    chk("rb_term", 128'({wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 128'h0);
    rst = 1'b0;
    set_req(0, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    chk("rb_tie", 128'(grant_o), 128'h1);
    wait_term(0, 20, n);
    chk("rb_m0_dat", 128'(wbm_dat_o[31:0]), 128'hDEADBEEF);
    m_cyc = '0;
    m_stb = '0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
